// File: rtl/sarg_pkg.sv
// Shared definitions for the SAR guess controller: FSM state encoding and
// default configuration values used by the controller and its bound-update
// helper.
package sarg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } sarg_state_e;

    localparam int SARG_WIDTH_DEFAULT   = 3;
    localparam int SARG_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/sarg_bound_update.sv
// Combinational bound narrowing for the SAR guess controller. Given the
// current search window, the current candidate and a comparator verdict it
// produces the narrowed window, the next midpoint candidate and a flag that
// marks a verdict that cannot belong to a consistent responder.
module sarg_bound_update
    import sarg_pkg::*;
#(
    parameter int WIDTH = SARG_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   lo,
    input  logic [WIDTH:0]   hi,
    input  logic [WIDTH-1:0] guess,
    input  logic             cmp_lt,
    input  logic             cmp_grt,
    input  logic             cmp_eq,
    output logic [WIDTH:0]   lo_next,
    output logic [WIDTH:0]   hi_next,
    output logic [WIDTH-1:0] guess_next,
    output logic             bad
);

    localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

    logic [WIDTH:0] guess_ext;
    logic [WIDTH:0] bound_sum;
    logic           one_hot;
    logic           edge_bad;

    assign guess_ext = {1'b0, guess};

    // Exactly one flag: odd number set, but not all three.
    assign one_hot = (cmp_lt ^ cmp_grt ^ cmp_eq) & ~(cmp_lt & cmp_grt & cmp_eq);

    // Narrow the window on the side the verdict rules out; stepping past
    // either end of the value range is an inconsistent answer.
    always_comb begin
        lo_next  = lo;
        hi_next  = hi;
        edge_bad = 1'b0;
        if (cmp_grt) begin
            lo_next  = guess_ext + ONE_EXT;
            edge_bad = &guess;
        end else if (cmp_lt) begin
            hi_next  = guess_ext - ONE_EXT;
            edge_bad = ~|guess;
        end
    end

    // Midpoint of the narrowed window, taken at WIDTH+1 bits so the sum
    // cannot overflow, then truncated back to the guess width.
    assign bound_sum  = lo_next + hi_next;
    assign guess_next = bound_sum[WIDTH:1];

    assign bad = ~one_hot | edge_bad | (lo_next > hi_next);

endmodule

// File: rtl/sar_guess_ctrl.sv
// Binary-search guess controller. Proposes a candidate on `guess`, consumes
// a LT/GRT/EQ verdict of secret-vs-guess from the magnitude comparator and
// narrows the search window until EQ, reporting the value and the number of
// verdicts used. Inconsistent verdicts park the FSM in ERR.
// Optional build macro SARG_TIMEOUT_EN adds a per-verdict watchdog that
// moves to ERR when no verdict arrives within TIMEOUT cycles.
module sar_guess_ctrl
    import sarg_pkg::*;
#(
    parameter int WIDTH   = SARG_WIDTH_DEFAULT,
    parameter int TIMEOUT = SARG_TIMEOUT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic [WIDTH-1:0]            guess,
    output logic                        guess_valid,
    input  logic                        cmp_valid,
    input  logic                        cmp_lt,
    input  logic                        cmp_grt,
    input  logic                        cmp_eq,
    output logic                        busy,
    output logic                        done,
    output logic [WIDTH-1:0]            result,
    output logic [$clog2(WIDTH+2)-1:0]  attempts,
    output logic                        error
);

    localparam int               AW         = $clog2(WIDTH+2);
    localparam logic [AW-1:0]    ATT_ONE    = AW'(1);
    localparam logic [WIDTH:0]   HI_INIT    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] GUESS_INIT = HI_INIT[WIDTH:1];

    sarg_state_e      state_q,    state_d;
    logic [WIDTH:0]   lo_q,       lo_d;
    logic [WIDTH:0]   hi_q,       hi_d;
    logic [WIDTH-1:0] guess_q,    guess_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic [AW-1:0]    attempts_q, attempts_d;

    logic [WIDTH:0]   upd_lo;
    logic [WIDTH:0]   upd_hi;
    logic [WIDTH-1:0] upd_guess;
    logic             upd_bad;

`ifdef SARG_TIMEOUT_EN
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
`endif

    sarg_bound_update #(
        .WIDTH      (WIDTH)
    ) u_bound (
        .lo         (lo_q),
        .hi         (hi_q),
        .guess      (guess_q),
        .cmp_lt     (cmp_lt),
        .cmp_grt    (cmp_grt),
        .cmp_eq     (cmp_eq),
        .lo_next    (upd_lo),
        .hi_next    (upd_hi),
        .guess_next (upd_guess),
        .bad        (upd_bad)
    );

    // Next-state logic: launch a search from any resting state, and in WAIT
    // consume one verdict per cmp_valid strobe.
    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        guess_d    = guess_q;
        result_d   = result_q;
        attempts_d = attempts_q;
`ifdef SARG_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = WAIT;
                    lo_d       = '0;
                    hi_d       = HI_INIT;
                    guess_d    = GUESS_INIT;
                    attempts_d = '0;
`ifdef SARG_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            WAIT: begin
                if (cmp_valid) begin
                    attempts_d = attempts_q + ATT_ONE;
`ifdef SARG_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                    if (upd_bad) begin
                        state_d = ERR;
                    end else if (cmp_eq) begin
                        result_d = guess_q;
                        state_d  = DONE;
                    end else begin
                        lo_d    = upd_lo;
                        hi_d    = upd_hi;
                        guess_d = upd_guess;
                    end
                end
`ifdef SARG_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lo_q       <= '0;
            hi_q       <= '0;
            guess_q    <= '0;
            result_q   <= '0;
            attempts_q <= '0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            guess_q    <= guess_d;
            result_q   <= result_d;
            attempts_q <= attempts_d;
        end
    end

`ifdef SARG_TIMEOUT_EN
    // Per-verdict watchdog counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign guess       = guess_q;
    assign guess_valid = (state_q == WAIT);
    assign busy        = (state_q == WAIT);
    assign done        = (state_q == DONE);
    assign error       = (state_q == ERR);
    assign result      = result_q;
    assign attempts    = attempts_q;

endmodule
